// File: rtl/srt_div_pkg.sv
// Shared types and constants for the iterative SRT divider.
// Build option: SRT_DIV_EARLY_TERM_EN (see srt_div_iter.sv).
package srt_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Widest operand the constant helpers can describe.
  localparam int unsigned MAX_W = 256;

  // Quotient returned on divide-by-zero: all ones in the low w bits.
  function automatic logic [MAX_W-1:0] dbz_quotient(input int unsigned w);
    logic [MAX_W-1:0] ones;
    ones = '1;
    return ones >> (MAX_W - w);
  endfunction

  // Most negative two's-complement value at width w.
  function automatic logic [MAX_W-1:0] signed_min(input int unsigned w);
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/srt_lzc.sv
// Leading-zero counter, purely combinational. An all-zero input yields WIDTH.
module srt_lzc
  import srt_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scan upward; the highest set bit is the last one to write the count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/srt_div_iter.sv
// Iterative radix-2 SRT divider, quotient digits {-1,+1}, final correction.
// Build option: SRT_DIV_EARLY_TERM_EN skips the leading quotient bits that are
// known to be zero, so ITER runs only lz(|divisor|)-lz(|dividend|)+1 cycles.
module srt_div_iter
  import srt_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             kill,
  output logic             input_ready,
  input  logic             input_valid,
  input  logic [WIDTH-1:0] input_bits_dividend,
  input  logic [WIDTH-1:0] input_bits_divisor,
  input  logic             input_bits_signed,
  input  logic             output_ready,
  output logic             output_valid,
  output logic [WIDTH-1:0] output_bits_quotient,
  output logic [WIDTH-1:0] output_bits_remainder,
  output logic             output_bits_div_by_zero
);

  localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(dbz_quotient(WIDTH));
  localparam logic [WIDTH-1:0] S_MIN = WIDTH'(signed_min(WIDTH));

  state_t           state;
  logic [WIDTH-1:0] dvd, dvs;      // operands as presented
  logic [WIDTH-1:0] a_sh;          // |dividend| bits still to be shifted in
  logic [WIDTH-1:0] b;             // |divisor|
  logic [WIDTH-1:0] q;             // digit accumulator, q = 2q + d
  logic [WIDTH:0]   p;             // signed partial remainder
  logic [CNT_W-1:0] cnt;
  logic             is_signed, sign_q, sign_r;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   p_sh, p_step;
  logic [WIDTH-1:0] q_sh, q_step, q_fix, r_fix;

  assign input_ready = (state == IDLE) && !kill && reset;

  // Operand magnitudes, one non-restoring step, and the final correction.
  always_comb begin
    neg_a = is_signed & dvd[WIDTH-1];
    neg_b = is_signed & dvs[WIDTH-1];
    abs_a = neg_a ? -dvd : dvd;
    abs_b = neg_b ? -dvs : dvs;
    p_sh  = {p[WIDTH-1:0], a_sh[WIDTH-1]};
    q_sh  = {q[WIDTH-2:0], 1'b0};
    if (p[WIDTH]) begin
      p_step = p_sh + {1'b0, b};
      q_step = q_sh - WIDTH'(1);
    end else begin
      p_step = p_sh - {1'b0, b};
      q_step = q_sh | WIDTH'(1);
    end
    r_fix = p[WIDTH] ? p[WIDTH-1:0] + b : p[WIDTH-1:0];
    q_fix = p[WIDTH] ? q - WIDTH'(1) : q;
  end

`ifdef SRT_DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lz_a, lz_b, shift;

  srt_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc_a (.value(abs_a), .count(lz_a));
  srt_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc_b (.value(abs_b), .count(lz_b));

  assign shift = lz_b - lz_a;
`endif

  // Control FSM and datapath registers; kill overrides every other transition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      dvd                     <= '0;
      dvs                     <= '0;
      is_signed               <= 1'b0;
      sign_q                  <= 1'b0;
      sign_r                  <= 1'b0;
      a_sh                    <= '0;
      b                       <= '0;
      q                       <= '0;
      p                       <= '0;
      cnt                     <= '0;
      output_valid            <= 1'b0;
      output_bits_quotient    <= '0;
      output_bits_remainder   <= '0;
      output_bits_div_by_zero <= 1'b0;
    end else if (kill) begin
      state        <= IDLE;
      output_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (input_valid) begin
            dvd       <= input_bits_dividend;
            dvs       <= input_bits_divisor;
            is_signed <= input_bits_signed;
            state     <= PREP;
          end
        end
        PREP: begin
          sign_q <= neg_a ^ neg_b;
          sign_r <= neg_a;
          b      <= abs_b;
          q      <= '0;
          if (dvs == '0) begin
            output_bits_quotient    <= DBZ_Q;
            output_bits_remainder   <= dvd;
            output_bits_div_by_zero <= 1'b1;
            output_valid            <= 1'b1;
            state                   <= DONE;
          end else if (is_signed && dvd == S_MIN && dvs == '1) begin
            output_bits_quotient    <= S_MIN;
            output_bits_remainder   <= '0;
            output_bits_div_by_zero <= 1'b0;
            output_valid            <= 1'b1;
            state                   <= DONE;
          end
`ifdef SRT_DIV_EARLY_TERM_EN
          else if (abs_a < abs_b) begin
            output_bits_quotient    <= '0;
            output_bits_remainder   <= dvd;
            output_bits_div_by_zero <= 1'b0;
            output_valid            <= 1'b1;
            state                   <= DONE;
          end else begin
            // The top bits of |dividend| form a restoring remainder below
            // |divisor|, so iteration starts from it with shift+1 bits left.
            cnt   <= shift + CNT_W'(1);
            p     <= {1'b0, abs_a >> (shift + CNT_W'(1))};
            a_sh  <= abs_a << (CNT_W'(WIDTH - 1) - shift);
            state <= ITER;
          end
`else
          else begin
            cnt   <= CNT_W'(WIDTH);
            p     <= '0;
            a_sh  <= abs_a;
            state <= ITER;
          end
`endif
        end
        ITER: begin
          p    <= p_step;
          q    <= q_step;
          a_sh <= {a_sh[WIDTH-2:0], 1'b0};
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          output_bits_quotient    <= sign_q ? -q_fix : q_fix;
          output_bits_remainder   <= sign_r ? -r_fix : r_fix;
          output_bits_div_by_zero <= 1'b0;
          output_valid            <= 1'b1;
          state                   <= DONE;
        end
        DONE: begin
          if (output_ready) begin
            output_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srt_div_iter.sv
// Self-checking bench for srt_div_iter at WIDTH=32: directed table, random
// operations against an arithmetic reference, kill and async-reset sequences.
// Latency is the number of edges from acceptance (t0) to the first edge at
// which output_valid is high.
module tb_srt_div_iter;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          kill = 1'b0;
  logic          input_ready;
  logic          input_valid = 1'b0;
  logic [W-1:0]  input_bits_dividend = '0;
  logic [W-1:0]  input_bits_divisor = '0;
  logic          input_bits_signed = 1'b0;
  logic          output_ready = 1'b1;
  logic          output_valid;
  logic [W-1:0]  output_bits_quotient;
  logic [W-1:0]  output_bits_remainder;
  logic          output_bits_div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  srt_div_iter #(.WIDTH(W)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .kill                   (kill),
    .input_ready            (input_ready),
    .input_valid            (input_valid),
    .input_bits_dividend    (input_bits_dividend),
    .input_bits_divisor     (input_bits_divisor),
    .input_bits_signed      (input_bits_signed),
    .output_ready           (output_ready),
    .output_valid           (output_valid),
    .output_bits_quotient   (output_bits_quotient),
    .output_bits_remainder  (output_bits_remainder),
    .output_bits_div_by_zero(output_bits_div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int           hold;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

`ifdef SRT_DIV_EARLY_TERM_EN
  function automatic int bitlen(input longint unsigned x);
    int n = 0;
    while (x != 0) begin
      x = x >> 1;
      n++;
    end
    return n;
  endfunction
`endif

  // Reference: plain integer division, truncating toward zero.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
    longint sa, sb;
    longint unsigned ma, mb;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    z = 1'b0;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1; lat = 2;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 2;
      else begin
`ifdef SRT_DIV_EARLY_TERM_EN
        if (ma < mb) lat = 2;
        else lat = bitlen(ma) - bitlen(mb) + 4;
`else
        lat = W + 3;
        if (ma == mb + 1) lat = W + 3;
`endif
      end
    end
  endtask

  // One full transaction with optional output backpressure, fully checked.
  task automatic check_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int hold, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic ez, input int elat);
    logic [W-1:0] cq, cr;
    logic cz;
    int lat, g;
    bit got, busy_ok, hold_ok;
    @(negedge clock);
    g = 0;
    while (!input_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    check({nm, "_accept"}, input_ready, 1);
    input_valid = 1'b1;
    input_bits_dividend = a;
    input_bits_divisor = b;
    input_bits_signed = s;
    output_ready = (hold == 0);
    @(posedge clock);
    #1;
    input_valid = 1'b0;
    input_bits_dividend = $urandom;
    input_bits_divisor = $urandom;
    input_bits_signed = 1'($urandom);
    lat = 0; got = 0; busy_ok = 1;
    while (lat < 200 && !got) begin
      @(negedge clock);
      lat++;
      if (output_valid) got = 1;
      else if (input_ready) busy_ok = 0;
    end
    check({nm, "_valid"}, got, 1);
    check({nm, "_busy"}, busy_ok, 1);
    cq = output_bits_quotient;
    cr = output_bits_remainder;
    cz = output_bits_div_by_zero;
    check({nm, "_q"}, cq, eq);
    check({nm, "_r"}, cr, er);
    check({nm, "_dbz"}, cz, ez);
    check({nm, "_lat"}, lat, elat);
    if (got && hold > 0) begin
      hold_ok = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        if (!output_valid || input_ready || output_bits_quotient !== cq ||
            output_bits_remainder !== cr || output_bits_div_by_zero !== cz) hold_ok = 0;
      end
      check({nm, "_hold"}, hold_ok, 1);
    end
    output_ready = 1'b1;
    @(negedge clock);
    check({nm, "_drop"}, output_valid, 0);
    check({nm, "_idle"}, input_ready, 1);
  endtask

  initial begin
    logic [W-1:0] a, b, mq, mr;
    logic s, mz;
    int lat, hold, mode, g;
    bit quiet;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 0, 32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'hFFFF_FFF9, 32'h2,         1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h7,         32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'h1,         1'b0};
    vecs[3]  = '{32'h1234,      32'h0,         1'b0, 0, 32'hFFFF_FFFF, 32'h1234,      1'b1};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'h0,         1'b0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h10,        1'b0, 5, 32'h0FFF_FFFF, 32'hF,         1'b0};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 32'h0,         32'h8000_0000, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h1,         1'b0, 0, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[8]  = '{32'h8000_0000, 32'h1,         1'b1, 0, 32'h8000_0000, 32'h0,         1'b0};
    vecs[9]  = '{32'd5,         32'd3,         1'b0, 0, 32'd1,         32'd2,         1'b0};
    vecs[10] = '{32'd3,         32'd5,         1'b0, 0, 32'd0,         32'd3,         1'b0};
    vecs[11] = '{32'hFFFF_FF9C, 32'h0,         1'b1, 2, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1};
    vecs[12] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 0, 32'd3,         32'hFFFF_FFFF, 1'b0};

    // Reset state, held asynchronously from time zero.
    #1;
    check("rst_ready", input_ready, 0);
    check("rst_valid", output_valid, 0);
    check("rst_q", output_bits_quotient, 0);
    check("rst_r", output_bits_remainder, 0);
    check("rst_dbz", output_bits_div_by_zero, 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      model(vecs[i].a, vecs[i].b, vecs[i].s, mq, mr, mz, lat);
      check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hold,
               vecs[i].q, vecs[i].r, vecs[i].z, lat);
    end

    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      hold = $urandom_range(0, 2);
      case (mode)
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
        2: b = W'($urandom_range(1, 15));
        3: b = b >> $urandom_range(0, 31);
        4: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      model(a, b, s, mq, mr, mz, lat);
      check_op($sformatf("rnd%0d", i), a, b, s, hold, mq, mr, mz, lat);
    end

    // Kill during the 10th ITER cycle: result must never appear.
    @(negedge clock);
    g = 0;
    while (!input_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    input_valid = 1'b1;
    input_bits_dividend = 32'd100;
    input_bits_divisor = 32'd7;
    input_bits_signed = 1'b0;
    @(posedge clock);
    #1;
    input_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      if (k == 11) kill = 1'b1;
    end
    #1;
    check("kill_ready_low", input_ready, 0);
    @(negedge clock);
    kill = 1'b0;
    #1;
    check("kill_valid", output_valid, 0);
    check("kill_idle", input_ready, 1);
    quiet = 1;
    for (int k = 0; k < W + 8; k++) begin
      @(negedge clock);
      if (output_valid) quiet = 0;
    end
    check("kill_never_valid", quiet, 1);

    // Asynchronous reset in the middle of ITER.
    input_valid = 1'b1;
    input_bits_dividend = 32'hFFFF_FFFF;
    input_bits_divisor = 32'd3;
    @(posedge clock);
    #1;
    input_valid = 1'b0;
    repeat (8) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", output_valid, 0);
    check("arst_q", output_bits_quotient, 0);
    check("arst_r", output_bits_remainder, 0);
    check("arst_dbz", output_bits_div_by_zero, 0);
    check("arst_ready", input_ready, 0);
    @(negedge clock);
    reset = 1'b1;
    model(32'd100, 32'd7, 1'b0, mq, mr, mz, lat);
    check_op("post_reset", 32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
